// File: rtl/disp_scan_4d_if.sv
// Bundle of display data inputs and multiplexed 7-segment drive outputs
// for the 4-digit scanner.
interface disp_scan_4d_if;
   logic [15:0] hexs;
   logic [3:0]  dp_in;
   logic        en;
   logic [6:0]  segment;
   logic        dp;
   logic [3:0]  AN;
   logic        frame_done;

   modport master (
      output hexs, dp_in, en,
      input  segment, dp, AN, frame_done
   );

   modport slave (
      input  hexs, dp_in, en,
      output segment, dp, AN, frame_done
   );
endinterface

// File: rtl/disp_scan_4d.sv
// Time-multiplexed 4-digit 7-segment scanner with frame capture,
// leading-zero blanking and registered active-low outputs.
module disp_scan_4d #(
   parameter int SCAN_DIV = 50000,
   parameter int LZ_BLANK = 1
) (
   input  logic           clk,
   input  logic           rst,
   disp_scan_4d_if.slave  bus
);
   localparam int            PW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

   logic [PW-1:0] presc_r;
   logic [PW-1:0] presc_nxt_s;
   logic [1:0]    idx_r;
   logic [1:0]    idx_nxt_s;
   logic [15:0]   frame_hex_r;
   logic [3:0]    frame_dp_r;
   logic          tick_s;
   logic          capture_s;
   logic [3:0]    nib_s;
   logic          blank_s;
   logic [6:0]    seg_nxt_s;
   logic          dp_nxt_s;
   logic [3:0]    an_nxt_s;
   logic [6:0]    seg_r;
   logic          dp_r;
   logic [3:0]    an_r;
   logic          frame_done_r;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
      case (v)
         4'h0:    hex_to_seg = 7'b1000000;
         4'h1:    hex_to_seg = 7'b1111001;
         4'h2:    hex_to_seg = 7'b0100100;
         4'h3:    hex_to_seg = 7'b0110000;
         4'h4:    hex_to_seg = 7'b0011001;
         4'h5:    hex_to_seg = 7'b0010010;
         4'h6:    hex_to_seg = 7'b0000010;
         4'h7:    hex_to_seg = 7'b1111000;
         4'h8:    hex_to_seg = 7'b0000000;
         4'h9:    hex_to_seg = 7'b0010000;
         4'hA:    hex_to_seg = 7'b0001000;
         4'hB:    hex_to_seg = 7'b0000011;
         4'hC:    hex_to_seg = 7'b1000110;
         4'hD:    hex_to_seg = 7'b0100001;
         4'hE:    hex_to_seg = 7'b0000110;
         4'hF:    hex_to_seg = 7'b0001110;
         default: hex_to_seg = 7'h7F;
      endcase
   endfunction

   // A digit is a leading zero when it and every digit to its left are zero;
   // the rightmost digit always shows.
   function automatic logic is_lead_zero(input logic [15:0] f, input logic [1:0] i);
      case (i)
         2'd3:    is_lead_zero = (f[15:12] == 4'h0);
         2'd2:    is_lead_zero = (f[15:8]  == 8'h00);
         2'd1:    is_lead_zero = (f[15:4]  == 12'h000);
         default: is_lead_zero = 1'b0;
      endcase
   endfunction

   // Next prescaler / digit index; capture happens on the 3 -> 0 wrap tick.
   always_comb begin
      tick_s    = (presc_r == PRESC_LAST);
      capture_s = tick_s && (idx_r == 2'd3);
      if (tick_s) begin
         presc_nxt_s = {PW{1'b0}};
         idx_nxt_s   = idx_r + 2'd1;
      end else begin
         presc_nxt_s = presc_r + PW'(1);
         idx_nxt_s   = idx_r;
      end
   end

   // Scan state and frame register.
   always_ff @(posedge clk) begin
      if (rst) begin
         presc_r     <= {PW{1'b0}};
         idx_r       <= 2'd0;
         frame_hex_r <= 16'h0000;
         frame_dp_r  <= 4'h0;
      end else begin
         presc_r <= presc_nxt_s;
         idx_r   <= idx_nxt_s;
         if (capture_s) begin
            frame_hex_r <= bus.hexs;
            frame_dp_r  <= bus.dp_in;
         end else begin
            frame_hex_r <= frame_hex_r;
            frame_dp_r  <= frame_dp_r;
         end
      end
   end

   // Drive for the current slot, taken only from the captured frame.
   always_comb begin
      nib_s   = frame_hex_r[{idx_r, 2'b00} +: 4];
      blank_s = (LZ_BLANK != 0) && is_lead_zero(frame_hex_r, idx_r);
      if (bus.en && !blank_s) begin
         an_nxt_s  = ~(4'b0001 << idx_r);
         seg_nxt_s = hex_to_seg(nib_s);
         dp_nxt_s  = ~frame_dp_r[idx_r];
      end else begin
         an_nxt_s  = 4'b1111;
         seg_nxt_s = 7'h7F;
         dp_nxt_s  = 1'b1;
      end
   end

   // Output registers: one cycle behind the scan state.
   always_ff @(posedge clk) begin
      if (rst) begin
         an_r         <= 4'b1111;
         seg_r        <= 7'h7F;
         dp_r         <= 1'b1;
         frame_done_r <= 1'b0;
      end else begin
         an_r         <= an_nxt_s;
         seg_r        <= seg_nxt_s;
         dp_r         <= dp_nxt_s;
         frame_done_r <= capture_s;
      end
   end

   assign bus.AN         = an_r;
   assign bus.segment    = seg_r;
   assign bus.dp         = dp_r;
   assign bus.frame_done = frame_done_r;
endmodule

// File: tb/tb_disp_scan_4d.sv
// Scoreboard bench: three scanner configurations share one stimulus stream,
// each checked every cycle against a slot-arithmetic reference model.
module tb_disp_scan_4d;
   logic        clk = 1'b0;
   logic        rst_v;
   logic [15:0] hexs_v;
   logic [3:0]  dp_v;
   logic        en_v;
   int          errors = 0;
   int          checks = 0;
   logic [6:0]  seg_tab [16];

   always #5 clk = ~clk;

   initial begin
      seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                  7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                  7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
   end

   for (genvar g = 0; g < 3; g++) begin : g_inst
      localparam int D  = (g == 2) ? 1 : 4;
      localparam int LZ = (g == 1) ? 0 : 1;

      disp_scan_4d_if bus ();
      assign bus.hexs  = hexs_v;
      assign bus.dp_in = dp_v;
      assign bus.en    = en_v;

      disp_scan_4d #(.SCAN_DIV(D), .LZ_BLANK(LZ)) dut (
         .clk (clk),
         .rst (rst_v),
         .bus (bus.slave)
      );

      logic [15:0] m_frame;
      logic [3:0]  m_fdp;
      int          m_cnt;
      logic [12:0] expq [$];

      // Reference: m_cnt = cycles since reset within a 4*D frame.
      initial begin
         int          slot;
         logic [12:0] e;
         logic [3:0]  an_e;
         forever begin
            @(posedge clk);
            if (rst_v) begin
               e       = {4'hF, 7'h7F, 1'b1, 1'b0};
               m_frame = 16'h0000;
               m_fdp   = 4'h0;
               m_cnt   = 0;
            end else begin
               slot = (m_cnt / D) % 4;
               if (!en_v || (LZ != 0 && slot > 0 && (m_frame >> (4 * slot)) == 16'h0000)) begin
                  e[12:1] = {4'hF, 7'h7F, 1'b1};
               end else begin
                  an_e       = 4'b1111;
                  an_e[slot] = 1'b0;
                  e[12:1]    = {an_e, seg_tab[m_frame[4 * slot +: 4]], ~m_fdp[slot]};
               end
               e[0] = (m_cnt == 4 * D - 1);
               if (e[0]) begin
                  m_frame = hexs_v;
                  m_fdp   = dp_v;
               end
               m_cnt = (m_cnt + 1) % (4 * D);
            end
            expq.push_back(e);
         end
      end

      // Monitor: compare registered outputs half a cycle after each edge.
      initial begin
         logic [12:0] e;
         logic [12:0] a;
         forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
               e = expq.pop_front();
               a = {bus.AN, bus.segment, bus.dp, bus.frame_done};
               checks++;
               if (a !== e) begin
                  errors++;
                  $display("FAIL out_cfg%0d t=%0t got AN=%b seg=%b dp=%b fd=%b want AN=%b seg=%b dp=%b fd=%b",
                           g, $time, a[12:9], a[8:2], a[1], a[0], e[12:9], e[8:2], e[1], e[0]);
               end
            end
         end
      end
   end

   task automatic run(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [12:0] a, input logic [12:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s t=%0t got AN=%b seg=%b dp=%b fd=%b want AN=%b seg=%b dp=%b fd=%b",
                  tag, $time, a[12:9], a[8:2], a[1], a[0], e[12:9], e[8:2], e[1], e[0]);
      end
   endtask

   initial begin
      logic [31:0] r;
      int          waited;
      bit          seen;
      rst_v  = 1'b1;
      hexs_v = 16'h0000;
      dp_v   = 4'h0;
      en_v   = 1'b1;
      run(2);
      chk("reset_cfg0", {g_inst[0].bus.AN, g_inst[0].bus.segment, g_inst[0].bus.dp, g_inst[0].bus.frame_done},
          {4'hF, 7'h7F, 1'b1, 1'b0});
      chk("reset_cfg1", {g_inst[1].bus.AN, g_inst[1].bus.segment, g_inst[1].bus.dp, g_inst[1].bus.frame_done},
          {4'hF, 7'h7F, 1'b1, 1'b0});
      chk("reset_cfg2", {g_inst[2].bus.AN, g_inst[2].bus.segment, g_inst[2].bus.dp, g_inst[2].bus.frame_done},
          {4'hF, 7'h7F, 1'b1, 1'b0});
      rst_v  = 1'b0;
      hexs_v = 16'h1234;
      run(50);
      hexs_v = 16'h00A0;
      run(48);
      hexs_v = 16'h1111;
      run(37);
      hexs_v = 16'h2222;
      run(40);
      hexs_v = 16'h8888;
      dp_v   = 4'b0100;
      run(20);
      en_v   = 1'b0;
      run(21);
      en_v   = 1'b1;
      run(30);
      hexs_v = 16'hFEDC;
      run(9);
      rst_v  = 1'b1;
      run(1);
      rst_v  = 1'b0;
      run(40);
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 15) == 0) begin
            r      = $urandom;
            hexs_v = 16'(r >> (4 * $urandom_range(0, 4)));
            dp_v   = 4'($urandom);
         end
         en_v  = ($urandom_range(0, 9) != 0);
         rst_v = ($urandom_range(0, 199) == 0);
         run(1);
      end
      rst_v = 1'b0;
      en_v  = 1'b1;
      run(20);
      waited = 0;
      seen   = 1'b0;
      while (!seen && waited < 20) begin
         run(1);
         waited++;
         if (g_inst[0].bus.frame_done === 1'b1) begin
            seen = 1'b1;
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL frame_done wait expired after %0d cycles t=%0t", waited, $time);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/disp_scan_4d.md
DISP_SCAN_4D -- requirements
Module: disp_scan_4d

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clock cycles per digit slot; legal range >= 1.
REQ-002 Parameter LZ_BLANK, default 1: 1 enables leading-zero blanking, 0 disables it.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1: synchronous, active-high reset.
REQ-005 Port hexs  input  16: value to display; digit i = hexs[4i+3:4i], digit 3 leftmost.
REQ-006 Port dp_in  input  4: decimal point request per digit, 1 = lit, bit i maps to digit i.
REQ-007 Port en  input  1: 1 = display on, 0 = all digits dark.
REQ-008 Port segment  output  7: active-low segments; segment[0]=a through segment[6]=g.
REQ-009 Port dp  output  1: active-low decimal point.
REQ-010 Port AN  output  4: active-low digit anodes; AN[i] selects digit i.
REQ-011 Port frame_done  output  1: one-cycle pulse after each frame capture.

Function
REQ-012 Prescaler counts 0..SCAN_DIV-1 every cycle, wraps to 0; tick = (prescaler == SCAN_DIV-1).
REQ-013 SCAN_DIV = 1: tick asserted every cycle.
REQ-014 Digit index idx (2 bits) advances by 1 on each tick; it wraps from 3 to 0.
REQ-015 On the tick edge where idx goes 3 -> 0, hexs and dp_in are captured into a frame register; all displayed data comes only from the frame register.
REQ-016 Changes on hexs or dp_in between captures have no visible effect until the next capture; no tearing within a frame.
REQ-017 frame_done is high for exactly the one cycle following each capture edge; low otherwise.
REQ-018 segment, dp and AN are registered; they reflect the idx value and frame register contents from the preceding cycle (1-cycle latency).
REQ-019 For the selected digit, AN has only bit idx low; segment is the hex decode of the frame nibble; dp is ~frame_dp[idx].
REQ-020 Decode (segment[6:0] as g..a): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-021 LZ_BLANK = 1: digit i (i = 3..1) is blank when it and every higher digit in the frame register are zero; digit 0 is never blanked.
REQ-022 Blank digit: AN = 4'b1111, segment = 7'h7F, dp = 1 for that slot; slot timing unchanged.
REQ-023 en = 0: AN = 4'b1111, segment = 7'h7F, dp = 1 (1-cycle latency); prescaler, idx and capture keep running; frame_done still pulses.
REQ-024 At any time at most one AN bit is low.

Reset
REQ-025 When rst is high at a clock edge: prescaler = 0, idx = 0, frame register (value and dp) = 0, AN = 4'b1111, segment = 7'h7F, dp = 1, frame_done = 0.
REQ-026 Reset has priority over tick, capture and en; reset mid-frame discards the current frame and restarts at digit 0 slot with prescaler 0.
REQ-027 After reset release, frame register stays 0 until the first 3 -> 0 wrap; digit 0 then shows "0" with all other digits blanked (LZ_BLANK = 1).

Verification (SCAN_DIV = 4 unless noted)
REQ-028 Reset 2 cycles, hexs = 16'h1234, en = 1 -> frame_done pulses once every 16 cycles; after first capture, AN cycles 1110,1101,1011,0111 with 4 cycles each; segments 0011001, 0110000, 0100100, 1111001.
REQ-029 hexs = 16'h00A0, LZ_BLANK = 1 -> digits 3,2 slots AN = 1111, segment = 7F; digit 1 = 0001000; digit 0 = 1000000; LZ_BLANK = 0 -> digits 3,2 show 1000000.
REQ-030 Change hexs from 16'h1111 to 16'h2222 mid-frame -> remaining slots of that frame still show 1111001; 2222 (0100100) appears only after next frame_done.
REQ-031 dp_in = 4'b0100, en toggled 1 -> 0 -> 1 -> dp = 0 only in digit 2 slot while en = 1; with en = 0 AN = 1111, segment = 7F, dp = 1 one cycle after en falls.
REQ-032 Assert rst in digit 2 slot -> next cycle AN = 1111, segment = 7F, frame_done = 0; after release, first digit 0 slot begins with prescaler 0.
REQ-033 SCAN_DIV = 1, hexs = 16'hFEDC -> idx changes every cycle, frame_done every 4 cycles, segment sequence 1000110, 0100001, 0000110, 0001110.
